// File: rtl/count_window_pkg.sv
// count_window_pkg
//   Shared types and defaults for the measurement-window controller.
//   state_t   : controller FSM states
//   CNT_W_DEF : default width of the controlled counter / result
//   WIN_W_DEF : default width of window_len and the window timer
package count_window_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        COUNT  = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;

endpackage

// File: rtl/count_window_ctrl_window_timer.sv
// window_timer
//   Loadable down-counter that times the COUNT phase of a measurement window.
//   Ports:
//     clk      in   clock, rising edge
//     reset    in   synchronous, active-high; clears the timer
//     load     in   load load_val (takes priority over dec)
//     load_val in   WIN_W value to load
//     dec      in   decrement by one
//     last     out  timer value equals 1 (final cycle of the window)
module window_timer
    import count_window_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIN_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [WIN_W-1:0] value_q;
    logic [WIN_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (dec) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign last = (value_q == WIN_W'(1));

endmodule

// File: rtl/count_window_ctrl.sv
// count_window_ctrl
//   Sequences an external up-counter through a measurement window:
//   clear the counter, gate event_in into its enable for window_len cycles,
//   wait one settle cycle, then capture the count and hold it on a
//   valid/ack result interface.
//
//   Build option: define COUNT_WINDOW_AUTO_RESTART_EN to make result_ack
//   start the next window immediately (same window_len) instead of
//   returning to IDLE.
//
//   Ports:
//     clk          in   clock, rising edge
//     reset        in   synchronous, active-high
//     start        in   request a window (sampled in IDLE only)
//     window_len   in   window length in cycles, latched on accepted start
//     abort        in   cancel any operation in progress
//     event_in     in   event qualifier to be counted
//     cnt_enable   out  counter enable
//     cnt_reset    out  counter synchronous reset
//     cnt_value    in   counter value
//     busy         out  controller not idle
//     result_valid out  result/overflow valid, held until result_ack
//     result_ack   in   consumer accepts result
//     result       out  captured count
//     overflow     out  counter wrapped during the window
module count_window_ctrl
    import count_window_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] window_len,
    input  logic             abort,
    input  logic             event_in,
    output logic             cnt_enable,
    output logic             cnt_reset,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [CNT_W-1:0] result,
    output logic             overflow
);

    state_t           state_q, state_d;
    logic [WIN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             result_valid_q, result_valid_d;
    logic             timer_last;

    // The timer is reloaded from the latched length in every CLEAR cycle,
    // so auto-restarted windows reuse the original length.
    window_timer #(
        .WIN_W(WIN_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == CLEAR),
        .load_val (len_q),
        .dec      (state_q == COUNT),
        .last     (timer_last)
    );

    assign cnt_enable   = (state_q == COUNT) & event_in;
    assign cnt_reset    = (state_q == CLEAR) | reset;
    assign busy         = (state_q != IDLE);
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign overflow     = overflow_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                // A zero-length request is dropped rather than run.
                if (start && (window_len != '0)) begin
                    len_d   = window_len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                overflow_d = 1'b0;
                state_d    = COUNT;
            end
            COUNT: begin
                // An enabled increment from all-ones is a wrap.
                if (cnt_enable && (cnt_value == {CNT_W{1'b1}})) begin
                    overflow_d = 1'b1;
                end
                if (timer_last) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // The last COUNT increment has landed by now.
                if (!abort) begin
                    result_d = cnt_value;
                end
                state_d = DONE;
            end
            DONE: begin
                if (result_ack) begin
`ifdef COUNT_WINDOW_AUTO_RESTART_EN
                    state_d = CLEAR;
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // abort outranks ack and timer expiry.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end

        result_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            len_q          <= '0;
            result_q       <= '0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            result_q       <= result_d;
            overflow_q     <= overflow_d;
            result_valid_q <= result_valid_d;
        end
    end

endmodule

// File: tb/tb_count_window_ctrl.sv
// tb_count_window_ctrl
//   Directed bench for count_window_ctrl with a behavioural 8-bit up-counter
//   attached to cnt_enable/cnt_reset/cnt_value.
module tb_count_window_ctrl;

    localparam int CNT_W = 8;
    localparam int WIN_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIN_W-1:0] window_len;
    logic             abort;
    logic             event_in;
    logic             cnt_enable;
    logic             cnt_reset;
    logic [CNT_W-1:0] cnt_q;
    logic             busy;
    logic             result_valid;
    logic             result_ack;
    logic [CNT_W-1:0] result;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // External up-counter owned by the controller.
    always_ff @(posedge clk) begin
        if (cnt_reset) begin
            cnt_q <= '0;
        end else if (cnt_enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    count_window_ctrl #(
        .CNT_W(CNT_W),
        .WIN_W(WIN_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .window_len   (window_len),
        .abort        (abort),
        .event_in     (event_in),
        .cnt_enable   (cnt_enable),
        .cnt_reset    (cnt_reset),
        .cnt_value    (cnt_q),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ack   (result_ack),
        .result       (result),
        .overflow     (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Accept a start; returns at #1 into the CLEAR cycle.
    task automatic start_win(input int len);
        window_len = WIN_W'(len);
        start      = 1'b1;
        cycle();
        start      = 1'b0;
    endtask

    task automatic run_window(input int len, input bit toggle, input bit poke,
                              input bit hold, input int exp_res, input bit exp_ovf);
        logic ev;
        start_win(len);
        event_in = 1'b1;
        @(negedge clk);
        chk("clear_cnt_reset", cnt_reset, 1);
        chk("clear_cnt_enable", cnt_enable, 0);
        chk("clear_busy", busy, 1);
        for (int i = 0; i < len; i++) begin
            cycle();
            ev         = toggle ? ~i[0] : 1'b1;
            event_in   = ev;
            start      = poke;
            result_ack = poke;
            window_len = poke ? WIN_W'(2) : WIN_W'(len);
            @(negedge clk);
            if (i == 0 || i == len - 1) begin
                chk("count_cnt_enable", cnt_enable, ev);
                chk("count_cnt_reset", cnt_reset, 0);
            end
        end
        cycle();
        event_in   = 1'b1;
        start      = 1'b0;
        result_ack = 1'b0;
        @(negedge clk);
        chk("settle_cnt_enable", cnt_enable, 0);
        chk("settle_valid", result_valid, 0);
        cycle();
        @(negedge clk);
        chk("done_valid", result_valid, 1);
        chk("done_result", result, exp_res);
        chk("done_overflow", overflow, exp_ovf);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                cycle();
                @(negedge clk);
                chk("hold_valid", result_valid, 1);
                chk("hold_result", result, exp_res);
                chk("hold_overflow", overflow, exp_ovf);
            end
        end
        result_ack = 1'b1;
        cycle();
        result_ack = 1'b0;
        @(negedge clk);
        chk("ack_valid_drop", result_valid, 0);
`ifdef COUNT_WINDOW_AUTO_RESTART_EN
        chk("restart_cnt_reset", cnt_reset, 1);
        chk("restart_busy", busy, 1);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        @(negedge clk);
        chk("restart_abort_busy", busy, 0);
`else
        chk("ack_busy", busy, 0);
        cycle();
        @(negedge clk);
        chk("no_requeue_busy", busy, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        window_len = '0;
        abort      = 1'b0;
        event_in   = 1'b0;
        result_ack = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cnt_enable", cnt_enable, 0);
        chk("rst_cnt_reset", cnt_reset, 1);
        cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cnt_reset", cnt_reset, 0);

        // L=4, constant events, result held 5 cycles before ack.
        run_window(4, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        // L=10, alternating events starting with 1.
        run_window(10, 1'b1, 1'b0, 1'b0, 5, 1'b0);
        // L=300 wraps the 8-bit counter once: 300-256=44.
        run_window(300, 1'b0, 1'b0, 1'b0, 44, 1'b1);
        // Following short window clears overflow.
        run_window(3, 1'b0, 1'b0, 1'b0, 3, 1'b0);

        // Zero-length start is ignored.
        window_len = '0;
        start      = 1'b1;
        cycle();
        start      = 1'b0;
        @(negedge clk);
        chk("zero_len_busy", busy, 0);
        chk("zero_len_cnt_reset", cnt_reset, 0);

        // start/ack/window_len pokes during COUNT do not disturb the window.
        run_window(6, 1'b0, 1'b1, 1'b0, 6, 1'b0);

        // Abort in the 3rd COUNT cycle of L=8.
        start_win(8);
        event_in = 1'b1;
        repeat (3) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_cnt_enable", cnt_enable, 0);
        chk("abort_counter_kept", cnt_q, 3);
        for (int i = 0; i < 10; i++) begin
            cycle();
            @(negedge clk);
            chk("abort_no_valid", result_valid, 0);
        end

        // Reset during SETTLE of a wrapping window.
        start_win(258);
        event_in = 1'b1;
        repeat (259) cycle();
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_overflow", overflow, 1);
        reset = 1'b1;
        cycle();
        @(negedge clk);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_cnt_enable", cnt_enable, 0);
        chk("mid_rst_cnt_reset", cnt_reset, 1);
        cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_counter", cnt_q, 0);

        // Shortest legal window.
        run_window(1, 1'b0, 1'b0, 1'b0, 1, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
